countdown_timer: RTL and testbench

- Loadable 12-bit down-counter with run/pause control and a terminal-count pulse.
- Complements the existing free-running up-counter. Used by game logic for round timers and delays: load a value, start it, and get a one-cycle `expired` pulse when it reaches zero.
- Optional auto-reload mode for periodic events.

---
 rtl/countdown_timer.sv | 97 +++++++++
 tb/tb_countdown_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with run/pause control, terminal-count pulse
// and optional auto-reload for periodic events.
module countdown_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_n;
  logic [WIDTH-1:0] count_n;
  logic             expired_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      expired    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      expired    <= expired_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload_reg;
    expired_n = 1'b0;
    if (load) begin
      count_n  = load_value;
      reload_n = load_value;
      state_n  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && count != '0)
            state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (tick) begin
            // count <= 1 is terminal, so the decrement never wraps
            if (count > WIDTH'(1)) begin
              count_n = count - WIDTH'(1);
            end else begin
              expired_n = 1'b1;
              if (auto_reload && reload_reg != '0) begin
                count_n = reload_reg;
              end else begin
                count_n = '0;
                state_n = DONE;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause)
            state_n = RUN;
        end
        DONE: begin
          if (start && reload_reg != '0) begin
            count_n = reload_reg;
            state_n = RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_countdown_timer;

  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         tick;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         running;
  logic         expired;

  countdown_timer #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .start(start),
    .pause(pause),
    .tick(tick),
    .auto_reload(auto_reload),
    .count(count),
    .running(running),
    .expired(expired)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: timer is "armed" once started, may be "held"
  // by pause, and "finished" after a non-reloading terminal tick.
  int m_cnt;
  int m_rel;
  bit m_armed;
  bit m_held;
  bit m_fin;
  bit m_exp;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         ps;
    logic         tk;
    logic         ar;
    int           e_cnt;
    bit           e_run;
    bit           e_exp;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model(input bit rs, input bit ld, input int lv,
                       input bit st, input bit ps, input bit tk,
                       input bit ar);
    m_exp = 0;
    if (rs) begin
      m_cnt = 0; m_rel = 0;
      m_armed = 0; m_held = 0; m_fin = 0;
    end else if (ld) begin
      m_cnt = lv; m_rel = lv;
      m_armed = 0; m_held = 0; m_fin = 0;
    end else if (m_fin) begin
      if (st && m_rel > 0) begin
        m_cnt = m_rel; m_fin = 0; m_armed = 1;
      end
    end else if (!m_armed) begin
      if (st && m_cnt > 0) m_armed = 1;
    end else if (m_held) begin
      if (!ps) m_held = 0;
    end else if (ps) begin
      m_held = 1;
    end else if (tk) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_exp = 1;
        if (ar && m_rel > 0) m_cnt = m_rel;
        else begin
          m_armed = 0; m_fin = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit rs, input bit ld, input int lv,
                     input bit st, input bit ps, input bit tk,
                     input bit ar);
    reset = rs; load = ld; load_value = W'(lv);
    start = st; pause = ps; tick = tk; auto_reload = ar;
    @(posedge clock);
    model(rs, ld, lv, st, ps, tk, ar);
    #1;
    check("model_count", int'(count), m_cnt);
    check("model_running", int'(running), int'(m_armed && !m_held));
    check("model_expired", int'(expired), int'(m_exp));
  endtask

  task automatic idle(input int n, input bit tk, input bit ar);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, tk, ar);
  endtask

  int seen_exp;

  initial begin
    reset = 1; load = 0; load_value = '0;
    start = 0; pause = 0; tick = 0; auto_reload = 0;

    // reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    check("reset_count", int'(count), 0);
    check("reset_running", int'(running), 0);
    check("reset_expired", int'(expired), 0);
    idle(3, 1, 0);
    check("idle_ticks_count", int'(count), 0);

    // basic countdown from 5 as a vector table
    vt[0] = '{1'b1, W'(5), 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0};
    vt[1] = '{1'b0, W'(0), 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0};
    vt[2] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    vt[3] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    vt[4] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
    vt[5] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    vt[6] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vt[7] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vt[8] = '{1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vt[9] = '{1'b0, W'(0), 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cyc(0, vt[i].ld, int'(vt[i].lv), vt[i].st, vt[i].ps,
          vt[i].tk, vt[i].ar);
      check($sformatf("vec%0d_count", i), int'(count), vt[i].e_cnt);
      check($sformatf("vec%0d_running", i), int'(running),
            int'(vt[i].e_run));
      check($sformatf("vec%0d_expired", i), int'(expired),
            int'(vt[i].e_exp));
    end

    // pause mid-run with ticks held high
    cyc(0, 1, 10, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(3, 1, 0);
    check("pre_pause_count", int'(count), 7);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 1, 0);
    check("paused_count", int'(count), 7);
    check("paused_running", int'(running), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("resume_count", int'(count), 7);
    check("resume_running", int'(running), 1);
    idle(2, 1, 0);
    check("resumed_count", int'(count), 5);

    // auto-reload from 3
    cyc(0, 1, 3, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 1);
    seen_exp = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      seen_exp += int'(expired);
    end
    check("reload_pulses", seen_exp, 3);
    check("reload_running", int'(running), 1);
    check("reload_count", int'(count), 3);

    // load with tick in RUN takes priority, then restart from DONE
    cyc(0, 1, 6, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(2, 1, 0);
    cyc(0, 1, 9, 0, 0, 1, 0);
    check("prio_load_count", int'(count), 9);
    check("prio_load_running", int'(running), 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    idle(9, 1, 0);
    check("done_count", int'(count), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("restart_count", int'(count), 9);
    check("restart_running", int'(running), 1);

    // load 0 then start stays idle; reset mid-count gives no pulse
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    check("zero_start_running", int'(running), 0);
    check("zero_start_expired", int'(expired), 0);
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(3, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    check("abort_count", int'(count), 0);
    check("abort_expired", int'(expired), 0);
    idle(2, 1, 0);
    check("abort_after_expired", int'(expired), 0);

    // reload register of 1 pulses every cycle
    cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    seen_exp = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      seen_exp += int'(expired);
    end
    check("reload1_pulses", seen_exp, 4);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 24) == 0,
          int'($urandom_range(0, 7)),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
